scurve_threshold_scan: RTL

Downstream controller and consumer for the single-channel S-curve counter. It steps the discriminator DAC threshold over a programmed range. At each point it clears and starts the counter, waits for count completion, and captures the pulse and trigger counts. It then emits a 3-word record per point into the readout FIFO.

---
 rtl/scurve_threshold_scan_if.sv | 9 +
 rtl/scurve_threshold_scan.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/scurve_threshold_scan_if.sv
// rtl/scurve_threshold_scan_if.sv - readout word stream from the scan controller into the FIFO
interface scurve_threshold_scan_if;
    logic [15:0] Data_Out;
    logic        Data_Valid;
    logic        Data_Ready;

    modport master (output Data_Out, output Data_Valid, input Data_Ready);
    modport slave  (input Data_Out, input Data_Valid, output Data_Ready);
endinterface

// File: rtl/scurve_threshold_scan.sv
// rtl/scurve_threshold_scan.sv - S-curve DAC threshold scan controller emitting 3-word records per point
module scurve_threshold_scan #(
    parameter int DAC_WIDTH     = 10,
    parameter int SETTLE_CYCLES = 1000,
    parameter int CLEAR_CYCLES  = 4
) (
    input  logic                   Clk,
    input  logic                   reset_n,
    input  logic                   Scan_Start,
    input  logic                   Scan_Abort,
    input  logic [DAC_WIDTH-1:0]   Dac_Start,
    input  logic [DAC_WIDTH-1:0]   Dac_Stop,
    input  logic [DAC_WIDTH-1:0]   Dac_Step,
    output logic [DAC_WIDTH-1:0]   Dac_Value,
    output logic                   Dac_Load,
    input  logic                   Dac_Load_Done,
    output logic                   Count_Reset_n,
    output logic                   Test_Start,
    input  logic [15:0]            CPT_PULSE,
    input  logic [15:0]            CPT_TRIGGER,
    input  logic                   CPT_DONE,
    scurve_threshold_scan_if.master rd,
    output logic                   Scan_Busy,
    output logic                   Scan_Done
);

    typedef enum logic [3:0] {
        IDLE, LOAD, WAIT_LOAD, CLEAR, SETTLE, RUN,
        OUT_HDR, OUT_P, OUT_T, NEXT, FINISH
    } state_t;

    localparam int CNT_MAX = (SETTLE_CYCLES > CLEAR_CYCLES) ? SETTLE_CYCLES : CLEAR_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic [15:0]        pulse_q;
    logic [15:0]        trig_q;
    logic               start_q;
    logic               done_s1, done_s2, done_s3;

    logic               start_rise;
    logic               done_rise;
    logic               transfer;
    logic [DAC_WIDTH:0] next_sum;
    logic               last_point;
    logic [15:0]        hdr_word;

    assign start_rise = Scan_Start & ~start_q;
    assign done_rise  = done_s2 & ~done_s3;
    assign transfer   = rd.Data_Valid & rd.Data_Ready;
    // One extra bit so a step past the top code is seen as overflow, not a wrap to low codes.
    assign next_sum   = {1'b0, Dac_Value} + {1'b0, Dac_Step};
    assign last_point = (Dac_Step == '0) || next_sum[DAC_WIDTH] ||
                        (next_sum[DAC_WIDTH-1:0] > Dac_Stop);
    assign hdr_word   = {4'hC, 12'(Dac_Value)};

    // CPT_DONE comes from the counter clock domain; third stage only feeds edge detection.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            done_s1 <= 1'b0;
            done_s2 <= 1'b0;
            done_s3 <= 1'b0;
            start_q <= 1'b0;
        end else begin
            done_s1 <= CPT_DONE;
            done_s2 <= done_s1;
            done_s3 <= done_s2;
            start_q <= Scan_Start;
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            pulse_q       <= '0;
            trig_q        <= '0;
            Dac_Value     <= '0;
            Dac_Load      <= 1'b0;
            Count_Reset_n <= 1'b0;
            Test_Start    <= 1'b0;
            rd.Data_Out   <= '0;
            rd.Data_Valid <= 1'b0;
            Scan_Busy     <= 1'b0;
            Scan_Done     <= 1'b0;
        end else if (Scan_Abort) begin
            state         <= IDLE;
            Dac_Load      <= 1'b0;
            Count_Reset_n <= 1'b0;
            Test_Start    <= 1'b0;
            rd.Data_Valid <= 1'b0;
            Scan_Busy     <= 1'b0;
            Scan_Done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    Count_Reset_n <= 1'b0;
                    if (start_rise) begin
                        Dac_Value <= Dac_Start;
                        Dac_Load  <= 1'b1;
                        Scan_Busy <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    Dac_Load <= 1'b0;
                    state    <= WAIT_LOAD;
                end
                WAIT_LOAD: begin
                    if (Dac_Load_Done) begin
                        Count_Reset_n <= 1'b0;
                        Test_Start    <= 1'b0;
                        wait_cnt      <= CNT_W'(CLEAR_CYCLES - 1);
                        state         <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (wait_cnt == '0) begin
                        Count_Reset_n <= 1'b1;
                        wait_cnt      <= CNT_W'(SETTLE_CYCLES - 1);
                        state         <= SETTLE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                SETTLE: begin
                    if (wait_cnt == '0) begin
                        Test_Start <= 1'b1;
                        state      <= RUN;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RUN: begin
                    if (done_rise) begin
                        pulse_q       <= CPT_PULSE;
                        trig_q        <= CPT_TRIGGER;
                        Test_Start    <= 1'b0;
                        rd.Data_Out   <= hdr_word;
                        rd.Data_Valid <= 1'b1;
                        state         <= OUT_HDR;
                    end
                end
                OUT_HDR: begin
                    if (transfer) begin
                        rd.Data_Out <= pulse_q;
                        state       <= OUT_P;
                    end
                end
                OUT_P: begin
                    if (transfer) begin
                        rd.Data_Out <= trig_q;
                        state       <= OUT_T;
                    end
                end
                OUT_T: begin
                    if (transfer) begin
                        rd.Data_Valid <= 1'b0;
                        state         <= NEXT;
                    end
                end
                NEXT: begin
                    if (last_point) begin
                        Scan_Done <= 1'b1;
                        state     <= FINISH;
                    end else begin
                        Dac_Value <= next_sum[DAC_WIDTH-1:0];
                        Dac_Load  <= 1'b1;
                        state     <= LOAD;
                    end
                end
                FINISH: begin
                    Scan_Done     <= 1'b0;
                    Scan_Busy     <= 1'b0;
                    Count_Reset_n <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
